// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad scanner: drives active-low columns from an external scan index, assembles
// 4-cycle frames of row hits, rejects multi-key frames and debounces press/release.
module keypad_scan_decoder #(
    parameter int unsigned DEB_FRAMES = 4,
    parameter int unsigned REL_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] scan_idx,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } state_t;

    localparam logic [3:0] DEB_N = DEB_FRAMES[3:0];
    localparam logic [3:0] REL_N = REL_FRAMES[3:0];

    state_t     state_q, state_d;
    logic [1:0] idx_q;
    logic [3:0] col_q;
    logic       frame_ok_q;
    logic [1:0] hit_cnt_q, acc_cnt;
    logic [3:0] hit_code_q, acc_code;
    logic [3:0] cand_q, cand_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [3:0] rel_cnt_q, rel_cnt_d;
    logic       key_valid_q, key_valid_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_held_q, key_held_d;
    logic       frame_close;

    assign col_out   = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

    // Frame accumulation including this cycle's hits; lowest row wins within a cycle.
    always_comb begin
        acc_cnt  = (idx_q == 2'd0) ? 2'd0 : hit_cnt_q;
        acc_code = (idx_q == 2'd0) ? 4'd0 : hit_code_q;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_in[r]) begin
                if (acc_cnt == 2'd0) acc_code = {r[1:0], idx_q};
                if (acc_cnt != 2'd2) acc_cnt = acc_cnt + 2'd1;
            end
        end
    end

    assign frame_close = frame_ok_q && (idx_q == 2'd3);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        if (frame_close) begin
            case (state_q)
                IDLE: begin
                    if (acc_cnt == 2'd1) begin
                        cand_d    = acc_code;
                        deb_cnt_d = 4'd1;
                        if (DEB_N == 4'd1) key_valid_d = 1'b1;
                        else               state_d     = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (acc_cnt == 2'd1) begin
                        if (acc_code == cand_q) begin
                            deb_cnt_d = deb_cnt_q + 4'd1;
                            if (deb_cnt_q + 4'd1 == DEB_N) key_valid_d = 1'b1;
                        end else begin
                            cand_d    = acc_code;
                            deb_cnt_d = 4'd1;
                        end
                    end else begin
                        state_d   = IDLE;
                        deb_cnt_d = '0;
                    end
                end
                PRESSED: begin
                    if (acc_cnt == 2'd0) begin
                        rel_cnt_d = rel_cnt_q + 4'd1;
                        if (rel_cnt_q + 4'd1 == REL_N) begin
                            key_held_d = 1'b0;
                            state_d    = IDLE;
                            rel_cnt_d  = '0;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (key_valid_d) begin
                key_code_d = acc_code;
                key_held_d = 1'b1;
                state_d    = PRESSED;
                rel_cnt_d  = '0;
                deb_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            col_q       <= '1;
            frame_ok_q  <= 1'b0;
            hit_cnt_q   <= '0;
            hit_code_q  <= '0;
            cand_q      <= '0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= scan_idx;
            col_q       <= ~(4'b0001 << scan_idx);
            // Keyed on scan_idx so frame_ok rises together with idx_q==0, not from idx_q's reset value.
            frame_ok_q  <= frame_ok_q | (scan_idx == 2'd0);
            hit_cnt_q   <= acc_cnt;
            hit_code_q  <= acc_code;
            cand_q      <= cand_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule
